// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: host-side responder that turns UART byte frames into
// register-bus accesses and pushes one response byte per frame.
//
// Frames: 'W' addr data  -> bus write, reply 'K'
//         'R' addr       -> bus read,  reply with read data
//         anything else  -> reply 'E', frame error
// Build option: define UART_CMD_BRIDGE_CHECKSUM_EN to require a trailing
// XOR checksum byte on every W/R frame (mismatch -> 'E', no bus access).
//
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_rx_empty, i_rd_data       RX FIFO status / first-word-fall-through head
//   o_rd_uart                   RX FIFO pop (combinational, same-cycle capture)
//   i_tx_full                   TX FIFO full
//   o_wr_uart, o_wr_data        TX FIFO push (combinational) / response byte
//   o_bus_addr, o_bus_wdata     register bus address / write data
//   o_bus_we, o_bus_re          request strobes, held until i_bus_ready
//   i_bus_rdata, i_bus_ready    read data / access complete
//   o_busy                      FSM not idle
//   o_frame_err, o_err_cnt      abort/reject pulse and its saturating count
module uart_cmd_bridge #(
    parameter int unsigned      DBITS          = 8,
    parameter int unsigned      TIMEOUT_CYCLES = 1_000_000,
    parameter logic [DBITS-1:0] CMD_WR         = DBITS'(8'h57),
    parameter logic [DBITS-1:0] CMD_RD         = DBITS'(8'h52),
    parameter logic [DBITS-1:0] RSP_ACK        = DBITS'(8'h4B),
    parameter logic [DBITS-1:0] RSP_ERR        = DBITS'(8'h45)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_empty,
    input  logic [DBITS-1:0] i_rd_data,
    output logic             o_rd_uart,
    input  logic             i_tx_full,
    output logic             o_wr_uart,
    output logic [DBITS-1:0] o_wr_data,
    output logic [DBITS-1:0] o_bus_addr,
    output logic [DBITS-1:0] o_bus_wdata,
    output logic             o_bus_we,
    output logic             o_bus_re,
    input  logic [DBITS-1:0] i_bus_rdata,
    input  logic             i_bus_ready,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic [7:0]       o_err_cnt
);
    localparam int unsigned   TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_GET_CSUM = 3'd3,
        S_BUS      = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    // State entered after the last payload byte of a frame.
`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
    localparam state_t S_AFTER = S_GET_CSUM;
`else
    localparam state_t S_AFTER = S_BUS;
`endif

    state_t        state, state_nxt;
    logic [TW-1:0] to_cnt;
    logic          is_wr;
    logic          in_get, pop, cmd_ok, timeout, abort;
`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
    logic [DBITS-1:0] csum;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; abort flags every rejected or timed-out frame
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    if (cmd_ok) begin
                        state_nxt = S_GET_ADDR;
                    end else begin
                        state_nxt = S_RESP;
                        abort     = 1'b1;
                    end
                end
            end
            S_GET_ADDR: if (pop) state_nxt = is_wr ? S_GET_DATA : S_AFTER;
            S_GET_DATA: if (pop) state_nxt = S_AFTER;
`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
            S_GET_CSUM: begin
                if (pop) begin
                    if (i_rd_data == csum) begin
                        state_nxt = S_BUS;
                    end else begin
                        state_nxt = S_RESP;
                        abort     = 1'b1;
                    end
                end
            end
`endif
            S_BUS:  if (i_bus_ready) state_nxt = S_RESP;
            S_RESP: if (!i_tx_full)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // timeout only fires with the FIFO empty, so it never races a pop
        if (timeout) begin
            state_nxt = S_IDLE;
            abort     = 1'b1;
        end
    end

    // Combinational outputs and decodes
    always_comb begin
        in_get    = (state == S_GET_ADDR) || (state == S_GET_DATA) || (state == S_GET_CSUM);
        o_rd_uart = !i_rx_empty && (in_get || (state == S_IDLE));
        pop       = o_rd_uart;
        cmd_ok    = (i_rd_data == CMD_WR) || (i_rd_data == CMD_RD);
        timeout   = in_get && i_rx_empty && (to_cnt == TO_LAST);
        o_wr_uart = (state == S_RESP) && !i_tx_full;
        o_busy    = (state != S_IDLE);
    end

    // Frame capture, bus request, response byte, timeout and error counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt      <= '0;
            is_wr       <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_we    <= 1'b0;
            o_bus_re    <= 1'b0;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
            o_err_cnt   <= 8'd0;
        end else begin
            o_frame_err <= abort;
            if (abort && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;

            if ((state_nxt == S_IDLE) || pop) to_cnt <= '0;
            else if (in_get)                  to_cnt <= to_cnt + TW'(1);

            if (pop && (state == S_IDLE))     is_wr       <= (i_rd_data == CMD_WR);
            if (pop && (state == S_GET_ADDR)) o_bus_addr  <= i_rd_data;
            if (pop && (state == S_GET_DATA)) o_bus_wdata <= i_rd_data;

            // request rises the cycle after the last accepted byte
            if ((state != S_BUS) && (state_nxt == S_BUS)) begin
                o_bus_we <= is_wr;
                o_bus_re <= !is_wr;
            end
            if ((state == S_BUS) && i_bus_ready) begin
                o_bus_we  <= 1'b0;
                o_bus_re  <= 1'b0;
                o_wr_data <= is_wr ? RSP_ACK : i_bus_rdata;
            end
            if (abort) o_wr_data <= RSP_ERR;
        end
    end

`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
    // Running XOR of command, address and data bytes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                        csum <= '0;
        else if (pop && (state == S_IDLE)) csum <= i_rd_data;
        else if (pop)                      csum <= csum ^ i_rd_data;
    end
`endif

endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;
    localparam int unsigned TO = 16;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx_empty;
    logic [7:0] i_rd_data;
    logic       o_rd_uart;
    logic       i_tx_full;
    logic       o_wr_uart;
    logic [7:0] o_wr_data;
    logic [7:0] o_bus_addr;
    logic [7:0] o_bus_wdata;
    logic       o_bus_we;
    logic       o_bus_re;
    logic [7:0] i_bus_rdata;
    logic       i_bus_ready;
    logic       o_busy;
    logic       o_frame_err;
    logic [7:0] o_err_cnt;

    uart_cmd_bridge #(.DBITS(8), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rx_empty(i_rx_empty), .i_rd_data(i_rd_data), .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_wr_data(o_wr_data),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .o_bus_we(o_bus_we), .o_bus_re(o_bus_re),
        .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready),
        .o_busy(o_busy), .o_frame_err(o_frame_err), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] bytes;   // frame bytes, first byte in [31:24]
        int          n;
        bit          raw;     // send exactly these bytes (no checksum appended)
        int          lat;     // bus ready delay in cycles after request
        logic [7:0]  rsp;
        int          we;      // expected o_bus_we cycles
        int          re;      // expected o_bus_re cycles
        int          err;     // expected o_frame_err pulses
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] mem [256];      // register bank behind the bus
    logic [7:0] emem [256];     // reference model of the register bank
    int  fixed_lat, cur_lat, lat_cnt, tx_mode, exp_errc;
    bit  rand_lat;

    logic       s_pop, s_push, s_we, s_ready;
    logic [7:0] s_txd, s_addr, s_wd;
    int  n_we, n_re, n_err, n_badpop, n_both, n_unstable;
    logic       p_we, p_re;
    logic [7:0] p_addr, p_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] b, input int n, input bit raw);
        logic [7:0] x;
        logic [7:0] c;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = b[31-8*i -: 8];
            rxq.push_back(c);
            x = x ^ c;
        end
`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
        c = b[31:24];
        if (!raw && (c == 8'h57 || c == 8'h52)) rxq.push_back(x);
`else
        if (raw) x = 8'h00;
`endif
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge i_clk);
            if (rxq.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge i_clk);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Environment: RX FIFO, TX FIFO sink and register-bus slave, driven just after each edge
    initial begin
        logic [7:0] tmp;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h62;
        i_rx_empty = 1'b1; i_rd_data = 8'h00; i_tx_full = 1'b0;
        i_bus_ready = 1'b0; i_bus_rdata = 8'h00;
        lat_cnt = 0; cur_lat = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) begin
                i_bus_ready = 1'b0;
                lat_cnt = 0;
            end else begin
                if (s_pop && rxq.size() > 0) tmp = rxq.pop_front();
                if (s_push) txq.push_back(s_txd);
                if (s_we && s_ready) mem[s_addr] = s_wd;
                if (o_bus_we || o_bus_re) begin
                    i_bus_ready = (lat_cnt >= cur_lat);
                    lat_cnt++;
                end else begin
                    i_bus_ready = 1'b0;
                    lat_cnt = 0;
                    cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                end
            end
            i_bus_rdata = mem[o_bus_addr];
            case (tx_mode)
                1:       i_tx_full = 1'b1;
                2:       i_tx_full = ($urandom_range(0, 2) == 0);
                default: i_tx_full = 1'b0;
            endcase
            i_rx_empty = (rxq.size() == 0);
            i_rd_data  = i_rx_empty ? 8'h00 : rxq[0];
        end
    end

    // Mid-cycle sampling of DUT outputs
    initial begin
        n_we = 0; n_re = 0; n_err = 0; n_badpop = 0; n_both = 0; n_unstable = 0;
        p_we = 1'b0; p_re = 1'b0; p_addr = 8'h00; p_wd = 8'h00;
        s_pop = 1'b0; s_push = 1'b0; s_we = 1'b0; s_ready = 1'b0;
        s_txd = 8'h00; s_addr = 8'h00; s_wd = 8'h00;
        forever begin
            @(negedge i_clk);
            s_pop = o_rd_uart; s_push = o_wr_uart; s_txd = o_wr_data;
            s_we = o_bus_we; s_ready = i_bus_ready; s_addr = o_bus_addr; s_wd = o_bus_wdata;
            if (!i_rst) begin
                if (o_bus_we) n_we++;
                if (o_bus_re) n_re++;
                if (o_frame_err) n_err++;
                if (o_rd_uart && i_rx_empty) n_badpop++;
                if (o_bus_we && o_bus_re) n_both++;
                if (((o_bus_we && p_we) || (o_bus_re && p_re)) &&
                    (o_bus_addr != p_addr || o_bus_wdata != p_wd)) n_unstable++;
            end
            p_we = o_bus_we; p_re = o_bus_re; p_addr = o_bus_addr; p_wd = o_bus_wdata;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt [8];
        int         nv, we0, re0, er0, tx0, cnt, busy_n;
        bit         ok;
        logic [7:0] exp_rsp[$];
        logic [7:0] a, d, b;
        int         kind;

        i_rst = 1'b1; fixed_lat = 0; rand_lat = 1'b0; tx_mode = 0; exp_errc = 0;

        vt[0] = '{32'h5710A500, 3, 1'b0, 2, 8'h4B, 3, 0, 0};
        vt[1] = '{32'h523C0000, 2, 1'b0, 0, 8'h5E, 0, 1, 0};  // bank preload is addr^0x62
        vt[2] = '{32'h00000000, 1, 1'b0, 0, 8'h45, 0, 0, 1};
        vt[3] = '{32'h57207700, 3, 1'b0, 1, 8'h4B, 2, 0, 0};
        vt[4] = '{32'h52200000, 2, 1'b0, 3, 8'h77, 0, 4, 0};
        vt[5] = '{32'h52100000, 2, 1'b0, 0, 8'hA5, 0, 1, 0};
        nv = 6;
`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
        vt[6] = '{32'h5710A5E2, 4, 1'b1, 0, 8'h4B, 1, 0, 0};
        vt[7] = '{32'h5710A500, 4, 1'b1, 0, 8'h45, 0, 0, 1};
        nv = 8;
`endif

        repeat (3) @(negedge i_clk);
        check("reset_outputs",
              {8'h00, o_rd_uart, o_wr_uart, o_bus_we, o_bus_re, o_busy, o_frame_err, o_wr_data, o_bus_addr, o_bus_wdata[1:0]},
              32'h0);
        check("reset_err_cnt", o_err_cnt, 0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Directed frame table
        for (int i = 0; i < nv; i++) begin
            we0 = n_we; re0 = n_re; er0 = n_err; tx0 = txq.size();
            fixed_lat = vt[i].lat;
            @(negedge i_clk);
            push_frame(vt[i].bytes, vt[i].n, vt[i].raw);
            wait_idle(500, ok);
            check($sformatf("vec%0d_done", i), ok, 1);
            check($sformatf("vec%0d_tx_pushes", i), txq.size() - tx0, 1);
            if (txq.size() > tx0) check($sformatf("vec%0d_rsp", i), txq[txq.size()-1], vt[i].rsp);
            check($sformatf("vec%0d_we_cycles", i), n_we - we0, vt[i].we);
            check($sformatf("vec%0d_re_cycles", i), n_re - re0, vt[i].re);
            check($sformatf("vec%0d_err_pulses", i), n_err - er0, vt[i].err);
            if (vt[i].err != 0) exp_errc = sat_inc(exp_errc);
            check($sformatf("vec%0d_err_cnt", i), o_err_cnt, exp_errc);
        end
        check("wr_10_landed", mem[8'h10], 8'hA5);

        // Timeout: 57 10 then silence
        we0 = n_we; re0 = n_re; er0 = n_err; tx0 = txq.size();
        @(negedge i_clk);
        push_frame(32'h57100000, 2, 1'b1);
        for (int c = 0; c < 50 && rxq.size() != 0; c++) begin
            @(posedge i_clk);
            #2;
        end
        busy_n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            if (o_busy) busy_n++;
            else break;
        end
        repeat (2) @(negedge i_clk);
        check("timeout_busy_cycles", busy_n, TO);
        check("timeout_err_pulse", n_err - er0, 1);
        check("timeout_no_tx", txq.size() - tx0, 0);
        check("timeout_no_bus", (n_we - we0) + (n_re - re0), 0);
        exp_errc = sat_inc(exp_errc);
        check("timeout_err_cnt", o_err_cnt, exp_errc);
        tx0 = txq.size();
        fixed_lat = 0;
        push_frame(32'h52100000, 2, 1'b0);
        wait_idle(500, ok);
        check("after_timeout_tx", txq.size() - tx0, 1);
        if (txq.size() > tx0) check("after_timeout_rsp", txq[txq.size()-1], 8'hA5);

        // TX FIFO full for 20 cycles after the bus access
        re0 = n_re; tx0 = txq.size(); tx_mode = 1; fixed_lat = 1;
        @(negedge i_clk);
        push_frame(32'h523C0000, 2, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            if (n_re > re0 && !o_bus_re) begin ok = 1'b1; break; end
        end
        check("txfull_bus_done", ok, 1);
        busy_n = 0; cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_busy) busy_n++;
            if (o_wr_uart) cnt++;
        end
        check("txfull_no_push", cnt, 0);
        check("txfull_busy", busy_n, 20);
        tx_mode = 0;
        wait_idle(100, ok);
        check("txfull_one_push", txq.size() - tx0, 1);
        if (txq.size() > tx0) check("txfull_rsp", txq[txq.size()-1], 8'h5E);

        // Reset while a write request is pending
        fixed_lat = 6;
        @(negedge i_clk);
        push_frame(32'h57301100, 3, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge i_clk);
            if (o_bus_we) begin ok = 1'b1; break; end
        end
        check("midreset_we_seen", ok, 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("midreset_async_clear", {o_bus_we, o_busy, o_err_cnt}, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_errc = 0;
        repeat (3) @(negedge i_clk);
        check("midreset_no_write", mem[8'h30], 8'h52);
        check("midreset_idle", o_busy, 0);

        // Randomized frame stream against the reference bank model
        for (int i = 0; i < 256; i++) emem[i] = mem[i];
        tx_mode = 2; rand_lat = 1'b1; tx0 = txq.size();
        @(negedge i_clk);
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 4));
            a = 8'($urandom);
            d = 8'($urandom);
            if (kind <= 1) begin
                push_frame({8'h57, a, d, 8'h00}, 3, 1'b0);
                emem[a] = d;
                exp_rsp.push_back(8'h4B);
            end else if (kind <= 3) begin
                push_frame({8'h52, a, 16'h0000}, 2, 1'b0);
                exp_rsp.push_back(emem[a]);
            end else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                push_frame({b, 24'h000000}, 1, 1'b0);
                exp_rsp.push_back(8'h45);
                exp_errc = sat_inc(exp_errc);
            end
        end
        wait_idle(20000, ok);
        check("rand_done", ok, 1);
        check("rand_tx_count", txq.size() - tx0, 40);
        for (int f = 0; f < 40; f++)
            if (tx0 + f < txq.size()) check($sformatf("rand_rsp%0d", f), txq[tx0+f], exp_rsp[f]);
        check("rand_err_cnt", o_err_cnt, exp_errc);
        cnt = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != emem[i]) cnt++;
        check("rand_bank_mismatches", cnt, 0);
        tx_mode = 0; rand_lat = 1'b0; fixed_lat = 0;

        // Error counter saturation with back-to-back bad bytes
        tx0 = txq.size();
        @(negedge i_clk);
        for (int i = 0; i < 260; i++) push_frame(32'h00000000, 1, 1'b0);
        wait_idle(3000, ok);
        check("sat_done", ok, 1);
        check("sat_tx_count", txq.size() - tx0, 260);
        check("sat_err_cnt", o_err_cnt, 8'hFF);

        check("no_pop_when_empty", n_badpop, 0);
        check("never_we_and_re", n_both, 0);
        check("request_fields_stable", n_unstable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
